// File: rtl/mux_sel_seq.sv
// ---------------------------------------------------------------------------
// mux_sel_seq
//
// Purpose:
//   Clocked select-token generator for the dual-rail control channel of a
//   handshake mux stage. A programmable select pattern is replayed as a
//   stream of 4-phase, return-to-zero dual-rail tokens (one per mux
//   transfer). The acknowledge comes back asynchronously and is brought into
//   the clock domain through a SYNC_STAGES-deep flop synchronizer.
//
// Optional feature (macro MUX_SEL_SEQ_TIMEOUT_EN):
//   When defined, a per-phase watchdog counts cycles spent in REQ/RTZ. On
//   reaching TIMEOUT it drops both rails, sets the sticky err flag and parks
//   the FSM in HALT until reset. When undefined, err is tied low and the
//   handshake waits forever.
//
// Parameters:
//   LEN          pattern depth in tokens (>=1)
//   SYNC_STAGES  flop depth of the acknowledge synchronizer (>=2)
//   TIMEOUT      cycles allowed per handshake phase (watchdog build only)
//
// Ports:
//   clk          sole clock
//   rst          synchronous, active-high reset
//   en           allow issuing new tokens
//   cfg_we       load pattern and length (accepted only while idle)
//   cfg_pattern  bit i = select for token i (0 -> rail A, 1 -> rail B)
//   cfg_len      active tokens; 0 acts as 1, values above LEN clamp to LEN
//   ctl_a        dual-rail select, rail A (mux input 0), registered
//   ctl_b        dual-rail select, rail B (mux input 1), registered
//   actl_i       control acknowledge from the mux, asynchronous to clk
//   busy         FSM not in IDLE, registered
//   tok_cnt      completed tokens, wraps at 2^16
//   err          sticky handshake timeout (0 without the macro)
// ---------------------------------------------------------------------------
module mux_sel_seq #(
    parameter int LEN         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cfg_we,
    input  logic [LEN-1:0]           cfg_pattern,
    input  logic [$clog2(LEN+1)-1:0] cfg_len,
    output logic                     ctl_a,
    output logic                     ctl_b,
    input  logic                     actl_i,
    output logic                     busy,
    output logic [15:0]              tok_cnt,
    output logic                     err
);

    localparam int LW = $clog2(LEN + 1);
    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

    // Elaboration-time parameter sanity checks.
    if (LEN < 1) begin : g_chk_len
        $error("mux_sel_seq: LEN must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("mux_sel_seq: SYNC_STAGES must be >= 2");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65536) begin : g_chk_timeout
        $error("mux_sel_seq: TIMEOUT must be in 1..65536");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RTZ  = 2'd2;
`ifdef MUX_SEL_SEQ_TIMEOUT_EN
    localparam logic [1:0] HALT = 2'd3;
`endif

    // ---------------------------------------------------------------
    // Acknowledge synchronizer. Cleared by reset so a stale ack from a
    // handshake interrupted by reset cannot leak into the next token.
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   actl_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], actl_i};
        end
    end

    assign actl_s = sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [1:0]     state_q, state_d;
    logic [LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]  len_q, len_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           ctl_a_q, ctl_a_d;
    logic           ctl_b_q, ctl_b_d;
    logic           busy_q;

    logic [LW-1:0]  len_clamp;
    logic [IW-1:0]  idx_nxt;
    logic           sel_cur;
    logic           sel_nxt;

    // Length clamp: zero would leave the wrap compare unreachable, and
    // anything above LEN would index past the pattern.
    always_comb begin
        len_clamp = cfg_len;
        if (cfg_len == '0) begin
            len_clamp = LW'(1);
        end else if (cfg_len > LW'(LEN)) begin
            len_clamp = LW'(LEN);
        end
    end

    always_comb begin
        idx_nxt = idx_q + IW'(1);
        if (LW'(idx_q) == len_q - LW'(1)) begin
            idx_nxt = '0;
        end
    end

    assign sel_cur = pat_q[idx_q];
    assign sel_nxt = pat_q[idx_nxt];

`ifdef MUX_SEL_SEQ_TIMEOUT_EN
    logic [15:0] ph_q, ph_d;
    logic        err_q, err_d;
    logic        ph_expired;

    // Trips on the edge that would make the phase TIMEOUT cycles long.
    assign ph_expired = ((state_q == REQ) || (state_q == RTZ)) &&
                        (ph_q == 16'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ctl_a_d = ctl_a_q;
        ctl_b_d = ctl_b_q;

        case (state_q)
            IDLE: begin
                ctl_a_d = 1'b0;
                ctl_b_d = 1'b0;
                // Config load wins over starting a token in the same cycle.
                if (cfg_we) begin
                    pat_d = cfg_pattern;
                    len_d = len_clamp;
                    idx_d = '0;
                end else if (en) begin
                    state_d = REQ;
                    ctl_a_d = ~sel_cur;
                    ctl_b_d = sel_cur;
                end
            end

            REQ: begin
                if (actl_s) begin
                    state_d = RTZ;
                    ctl_a_d = 1'b0;
                    ctl_b_d = 1'b0;
                end
            end

            RTZ: begin
                ctl_a_d = 1'b0;
                ctl_b_d = 1'b0;
                if (!actl_s) begin
                    cnt_d = cnt_q + 16'd1;
                    idx_d = idx_nxt;
                    // en is only consulted between tokens, so dropping it
                    // mid-token lets the current 4-phase cycle finish.
                    if (en) begin
                        state_d = REQ;
                        ctl_a_d = ~sel_nxt;
                        ctl_b_d = sel_nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

`ifdef MUX_SEL_SEQ_TIMEOUT_EN
            HALT: begin
                ctl_a_d = 1'b0;
                ctl_b_d = 1'b0;
            end
`endif

            default: begin
                state_d = IDLE;
                ctl_a_d = 1'b0;
                ctl_b_d = 1'b0;
            end
        endcase

`ifdef MUX_SEL_SEQ_TIMEOUT_EN
        // Watchdog overrides any handshake progress seen on the same edge.
        if (ph_expired) begin
            state_d = HALT;
            ctl_a_d = 1'b0;
            ctl_b_d = 1'b0;
            cnt_d   = cnt_q;
            idx_d   = idx_q;
        end
`endif
    end

`ifdef MUX_SEL_SEQ_TIMEOUT_EN
    always_comb begin
        err_d = err_q | ph_expired;
        ph_d  = 16'd0;
        if ((state_d == state_q) && ((state_q == REQ) || (state_q == RTZ))) begin
            ph_d = ph_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q  <= 16'd0;
            err_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= LW'(1);
            idx_q   <= '0;
            cnt_q   <= 16'd0;
            ctl_a_q <= 1'b0;
            ctl_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ctl_a_q <= ctl_a_d;
            ctl_b_q <= ctl_b_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign ctl_a   = ctl_a_q;
    assign ctl_b   = ctl_b_q;
    assign busy    = busy_q;
    assign tok_cnt = cnt_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// Directed testbench for mux_sel_seq (LEN=8, SYNC_STAGES=2, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mux_sel_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        ctl_a;
    logic        ctl_b;
    logic        actl_i;
    logic        busy;
    logic [15:0] tok_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    // Ack source: either a 3-cycle echo of (ctl_a|ctl_b) or a manual level.
    logic [2:0] ack_pipe = 3'b000;
    bit         ack_auto = 1'b0;
    bit         ack_man  = 1'b0;

    // Rising rail edges recorded as tokens (0 = A, 1 = B).
    bit   tokq[$];
    logic pa = 1'b0;
    logic pb = 1'b0;

    always #5 clk = ~clk;

    assign actl_i = ack_auto ? ack_pipe[2] : ack_man;

    always @(posedge clk) ack_pipe <= {ack_pipe[1:0], ctl_a | ctl_b};

    always @(negedge clk) begin
        if (ctl_a === 1'b1 && pa !== 1'b1) tokq.push_back(1'b0);
        if (ctl_b === 1'b1 && pb !== 1'b1) tokq.push_back(1'b1);
        if (ctl_a === 1'b1 && ctl_b === 1'b1) overlap++;
        pa = ctl_a;
        pb = ctl_b;
    end

    mux_sel_seq #(.LEN(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .ctl_a(ctl_a), .ctl_b(ctl_b), .actl_i(actl_i),
        .busy(busy), .tok_cnt(tok_cnt), .err(err)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; ack_auto = 1'b0; ack_man = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tokq.delete();
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Stimulus only: run with auto-ack until tok_cnt hits target, then drop en
    // and wait for idle. Reports whether either wait ran out of budget.
    task automatic run_until(input int target, output bit to);
        int n;
        to = 1'b0;
        en = 1'b1; ack_auto = 1'b1;
        n = 0;
        while (tok_cnt !== 16'(target) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) to = 1'b1;
        en = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) to = 1'b1;
        ack_auto = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ctl_a !== 1'b0) begin failures++; $display("FAIL reset_ctl_a got=%b exp=0", ctl_a); end
        checks++; if (ctl_b !== 1'b0) begin failures++; $display("FAIL reset_ctl_b got=%b exp=0", ctl_b); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (tok_cnt !== 16'd0) begin failures++; $display("FAIL reset_tok_cnt got=%0d exp=0", tok_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_pattern();
        logic [7:0] p;
        bit to;
        int bad;
        p = 8'b1011_0010;
        do_reset();
        load(p, 4'd8);
        run_until(16, to);
        checks++; if (to) begin failures++; $display("FAIL pattern_budget got=expired exp=done"); end
        // tok_cnt reached 16 with the 17th token already launched; it completes.
        checks++; if (tok_cnt !== 16'd17) begin failures++; $display("FAIL pattern_tok_cnt got=%0d exp=17", tok_cnt); end
        checks++; if (tokq.size() != 17) begin failures++; $display("FAIL pattern_ntok got=%0d exp=17", tokq.size()); end
        bad = 0;
        for (int i = 0; i < tokq.size() && i < 17; i++) if (tokq[i] !== p[i % 8]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL pattern_seq got=%0d_bad_tokens exp=0", bad); end
    endtask

    task automatic test_len();
        logic [7:0] p;
        bit to;
        int bad;
        // len=3: A,B,B repeating
        p = 8'b0000_0110;
        do_reset(); load(p, 4'd3); run_until(6, to);
        checks++; if (to || tokq.size() != 7) begin failures++; $display("FAIL len3_ntok got=%0d exp=7 to=%b", tokq.size(), to); end
        bad = 0;
        for (int i = 0; i < tokq.size() && i < 7; i++) if (tokq[i] !== p[i % 3]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL len3_seq got=%0d_bad_tokens exp=0", bad); end
        // len=0 acts as 1: token 0 (A) repeats, never advancing to a B
        p = 8'b1111_1110;
        do_reset(); load(p, 4'd0); run_until(4, to);
        checks++; if (to || tokq.size() != 5) begin failures++; $display("FAIL len0_ntok got=%0d exp=5 to=%b", tokq.size(), to); end
        bad = 0;
        for (int i = 0; i < tokq.size(); i++) if (tokq[i] !== 1'b0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL len0_seq got=%0d_bad_tokens exp=0", bad); end
        // len=12 clamps to 8: token 8 wraps back to pattern bit 0
        p = 8'b1011_0010;
        do_reset(); load(p, 4'd12); run_until(9, to);
        checks++; if (to || tokq.size() != 10) begin failures++; $display("FAIL len12_ntok got=%0d exp=10 to=%b", tokq.size(), to); end
        bad = 0;
        for (int i = 0; i < tokq.size() && i < 10; i++) if (tokq[i] !== p[i % 8]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL len12_seq got=%0d_bad_tokens exp=0", bad); end
    endtask

    task automatic test_en_drop_cfg();
        do_reset();
        load(8'b0000_0011, 4'd2);
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        checks++; if (ctl_b !== 1'b1 || ctl_a !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL start_rail got=a%b_b%b_busy%b exp=a0_b1_busy1", ctl_a, ctl_b, busy); end
        // In REQ: drop en and try to overwrite the config.
        en = 1'b0; cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1;
        @(negedge clk); cfg_we = 1'b0;
        ack_man = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ctl_b !== 1'b1) begin failures++; $display("FAIL ack_lat_early got=%b exp=1", ctl_b); end
        @(negedge clk);
        checks++; if (ctl_b !== 1'b0 || ctl_a !== 1'b0) begin failures++; $display("FAIL ack_lat_drop got=a%b_b%b exp=a0_b0", ctl_a, ctl_b); end
        ack_man = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tok_cnt !== 16'd0 || busy !== 1'b1) begin failures++; $display("FAIL endrop_pre got=cnt%0d_busy%b exp=cnt0_busy1", tok_cnt, busy); end
        @(negedge clk);
        checks++; if (tok_cnt !== 16'd1 || busy !== 1'b0) begin failures++; $display("FAIL endrop_done got=cnt%0d_busy%b exp=cnt1_busy0", tok_cnt, busy); end
        // Next token uses pattern bit 1 = B; a stray config load would give A.
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        checks++; if (ctl_b !== 1'b1 || ctl_a !== 1'b0) begin failures++; $display("FAIL cfg_ignored got=a%b_b%b exp=a0_b1", ctl_a, ctl_b); end
        ack_man = 1'b1;
        repeat (3) @(negedge clk);
        ack_man = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ((ctl_a | ctl_b) !== 1'b0) begin failures++; $display("FAIL next_lat_early got=a%b_b%b exp=a0_b0", ctl_a, ctl_b); end
        @(negedge clk);
        checks++; if (ctl_b !== 1'b1 || tok_cnt !== 16'd2) begin failures++; $display("FAIL next_lat_rise got=b%b_cnt%0d exp=b1_cnt2", ctl_b, tok_cnt); end
        en = 1'b0; ack_man = 1'b1;
        repeat (3) @(negedge clk);
        ack_man = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || tok_cnt !== 16'd3) begin failures++; $display("FAIL drain got=busy%b_cnt%0d exp=busy0_cnt3", busy, tok_cnt); end
    endtask

    task automatic test_rst_mid();
        int n;
        do_reset();
        load(8'b0000_0001, 4'd8);
        en = 1'b1; ack_auto = 1'b1;
        n = 0;
        while (tok_cnt !== 16'd1 && n < 500) begin @(negedge clk); n++; end
        checks++; if (ctl_a !== 1'b1 || n >= 500) begin failures++; $display("FAIL rstmid_req got=a%b_n%0d exp=a1", ctl_a, n); end
        rst = 1'b1; en = 1'b0; ack_auto = 1'b0; ack_man = 1'b0;
        @(negedge clk);
        checks++; if ((ctl_a | ctl_b) !== 1'b0 || busy !== 1'b0 || tok_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_clear got=a%b_b%b_busy%b_cnt%0d exp=all0", ctl_a, ctl_b, busy, tok_cnt); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        // Reset also clears the pattern, so reload; idx must restart at 0 (B).
        load(8'b0000_0001, 4'd8);
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        checks++; if (ctl_b !== 1'b1 || ctl_a !== 1'b0) begin failures++; $display("FAIL rstmid_idx got=a%b_b%b exp=a0_b1", ctl_a, ctl_b); end
        en = 1'b0; ack_man = 1'b1;
        repeat (3) @(negedge clk);
        ack_man = 1'b0;
        repeat (4) @(negedge clk);
    endtask

`ifdef MUX_SEL_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        load(8'h00, 4'd1);
        @(negedge clk); en = 1'b1;
        repeat (16) @(negedge clk);
        checks++; if (err !== 1'b0 || ctl_a !== 1'b1) begin failures++; $display("FAIL to_early got=err%b_a%b exp=err0_a1", err, ctl_a); end
        @(negedge clk);
        checks++; if (err !== 1'b1 || (ctl_a | ctl_b) !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_trip got=err%b_a%b_b%b_busy%b exp=err1_a0_b0_busy1", err, ctl_a, ctl_b, busy); end
        ack_man = 1'b1;
        repeat (20) @(negedge clk);
        ack_man = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (err !== 1'b1 || busy !== 1'b1 || (ctl_a | ctl_b) !== 1'b0 || tok_cnt !== 16'd0) begin failures++; $display("FAIL to_halt got=err%b_busy%b_cnt%0d exp=err1_busy1_cnt0", err, busy, tok_cnt); end
        en = 1'b0;
        do_reset();
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL to_rst got=err%b_busy%b exp=err0_busy0", err, busy); end
    endtask
`endif

    task automatic test_invariants();
        checks++; if (overlap != 0) begin failures++; $display("FAIL rail_overlap got=%0d exp=0", overlap); end
`ifndef MUX_SEL_SEQ_TIMEOUT_EN
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_tied got=%b exp=0", err); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd1;
        test_reset();
        test_pattern();
        test_len();
        test_en_drop_cfg();
        test_rst_mid();
`ifdef MUX_SEL_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
